// File: rtl/mem_burst_responder.sv
// mem_burst_responder: on-chip word memory answering the arbiter's burst bus.
// Single-beat writes, single or burst reads returned after RD_LATENCY cycles.
//
// Ports:
//   clock, reset       sole clock, synchronous active-high reset
//   addr               byte address, word index = addr[MEM_WORDS_LOG2+1:2]
//   burst_len          read beats, 0 and 1 both mean one beat
//   data_in, wr        write data and write request
//   rd                 read request
//   data_out           registered read data, held while rd_valid is low
//   waitrequest        high while a read is in flight, initiator must hold
//   rd_valid           data_out carries a read beat this cycle
module mem_burst_responder #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BURSTLEN_WIDTH = 3,
    parameter int MEM_WORDS_LOG2 = 12,
    parameter int RD_LATENCY     = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [BURSTLEN_WIDTH-1:0] burst_len,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      wr,
    input  logic                      rd,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      waitrequest,
    output logic                      rd_valid
);

    typedef enum logic [1:0] {
        IDLE,
        LATENCY,
        BURST
    } state_t;

    localparam int DEPTH = 1 << MEM_WORDS_LOG2;
    localparam logic [3:0] LAT_INIT = 4'(RD_LATENCY - 1);
    localparam logic [MEM_WORDS_LOG2-1:0] ADDR_ONE = MEM_WORDS_LOG2'(1);
    localparam logic [BURSTLEN_WIDTH-1:0] BEAT_ONE = BURSTLEN_WIDTH'(1);

    state_t                    state;
    logic [DATA_WIDTH-1:0]     mem [DEPTH];
    logic [MEM_WORDS_LOG2-1:0] word_idx;
    logic [MEM_WORDS_LOG2-1:0] beat_addr;
    logic [BURSTLEN_WIDTH-1:0] beats_left;
    logic [3:0]                lat_cnt;
    logic                      wr_en;
    logic                      issue;
    logic                      unused_addr_bits;

    assign word_idx = addr[MEM_WORDS_LOG2+1:2];
    assign unused_addr_bits =
        ^{addr[ADDR_WIDTH-1:MEM_WORDS_LOG2+2], addr[1:0]};

    assign waitrequest = (state != IDLE);

    // A write wins over a simultaneous read; the read is dropped.
    assign wr_en = !reset && (state == IDLE) && wr;

    // The first beat is issued on the edge that ends the latency count,
    // so the beat shows up RD_LATENCY cycles after acceptance. BURST keeps
    // issuing until beats_left runs out, then spends one cycle leaving,
    // which keeps waitrequest high through the last rd_valid cycle.
    assign issue = ((state == LATENCY) && (lat_cnt == 4'd0)) ||
                   ((state == BURST) && (beats_left != '0));

    // Kept free of reset so the array maps onto block RAM.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[word_idx] <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            rd_valid   <= 1'b0;
            data_out   <= '0;
            beat_addr  <= '0;
            beats_left <= '0;
            lat_cnt    <= 4'd0;
        end else begin
            rd_valid <= issue;
            if (issue) begin
                data_out   <= mem[beat_addr];
                beat_addr  <= beat_addr + ADDR_ONE;
                beats_left <= beats_left - BEAT_ONE;
            end
            unique case (state)
                IDLE: begin
                    if (rd && !wr) begin
                        beat_addr  <= word_idx;
                        beats_left <= (burst_len == '0) ? BEAT_ONE
                                                        : burst_len;
                        lat_cnt    <= LAT_INIT;
                        state      <= LATENCY;
                    end
                end
                LATENCY: begin
                    if (lat_cnt == 4'd0) begin
                        state <= BURST;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                BURST: begin
                    if (beats_left == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_BURST_RESPONDER_CHECKS
    // Define MEM_BURST_RESPONDER_CHECKS to flag rd/wr collisions in IDLE.
    always_ff @(posedge clock) begin
        if (!reset && state == IDLE) begin
            assert (!(rd && wr))
            else $error("rd and wr asserted together");
        end
    end
`endif

endmodule

// File: tb/tb_mem_burst_responder.sv
// tb_mem_burst_responder: directed vectors for mem_burst_responder.
// Small array (16 words) so the wrap-around case is reachable.
module tb_mem_burst_responder;

    logic        clock;
    logic        reset;
    logic [31:0] addr;
    logic [2:0]  burst_len;
    logic [31:0] data_in;
    logic        wr;
    logic        rd;
    logic [31:0] data_out;
    logic        waitrequest;
    logic        rd_valid;

    int nvec;
    int nerr;
    logic [31:0] exp_w [8];

    mem_burst_responder #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .BURSTLEN_WIDTH(3),
        .MEM_WORDS_LOG2(4),
        .RD_LATENCY(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .addr(addr),
        .burst_len(burst_len),
        .data_in(data_in),
        .wr(wr),
        .rd(rd),
        .data_out(data_out),
        .waitrequest(waitrequest),
        .rd_valid(rd_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        wr = 1'b1;
        addr = a;
        data_in = d;
        @(negedge clock);
        wr = 1'b0;
    endtask

    // Expects n beats from exp_w after a fixed RD_LATENCY of 2.
    // Command fields are scrambled after acceptance; hold keeps rd high.
    task automatic read_check(input logic [31:0] a, input logic [2:0] bl,
                              input int n, input logic hold);
        @(negedge clock);
        rd = 1'b1;
        addr = a;
        burst_len = bl;
        @(negedge clock);
        if (!hold) rd = 1'b0;
        addr = ~a;
        burst_len = 3'd7;
        chk("acc_wait", waitrequest, 1'b1);
        chk("acc_valid", rd_valid, 1'b0);
        @(negedge clock);
        chk("lat_wait", waitrequest, 1'b1);
        chk("lat_valid", rd_valid, 1'b0);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            chk("beat_valid", rd_valid, 1'b1);
            chk("beat_data", data_out, exp_w[i]);
            chk("beat_wait", waitrequest, 1'b1);
        end
        @(negedge clock);
        rd = 1'b0;
        chk("end_valid", rd_valid, 1'b0);
        chk("end_wait", waitrequest, 1'b0);
        chk("end_hold", data_out, exp_w[n-1]);
        @(negedge clock);
        chk("post_valid", rd_valid, 1'b0);
        chk("post_wait", waitrequest, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nvec = 0;
        nerr = 0;
        reset = 1'b1;
        addr = '0;
        burst_len = '0;
        data_in = '0;
        wr = 1'b0;
        rd = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("rst_wait", waitrequest, 1'b0);
        chk("rst_valid", rd_valid, 1'b0);
        chk("rst_data", data_out, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("idle_wait", waitrequest, 1'b0);
            chk("idle_valid", rd_valid, 1'b0);
            chk("idle_data", data_out, 32'h0);
        end

        write_word(32'h100, 32'hDEADBEEF);
        exp_w[0] = 32'hDEADBEEF;
        read_check(32'h100, 3'd0, 1, 1'b0);

        write_word(32'h200, 32'h11);
        write_word(32'h204, 32'h22);
        write_word(32'h208, 32'h33);
        write_word(32'h20C, 32'h44);
        exp_w[0] = 32'h11;
        exp_w[1] = 32'h22;
        exp_w[2] = 32'h33;
        exp_w[3] = 32'h44;
        read_check(32'h200, 3'd4, 4, 1'b1);
        exp_w[0] = 32'h33;
        read_check(32'h208, 3'd1, 1, 1'b0);

        write_word(32'h3C, 32'hA);
        write_word(32'h00, 32'hB);
        exp_w[0] = 32'hA;
        exp_w[1] = 32'hB;
        read_check(32'h3C, 3'd2, 2, 1'b0);

        // Mid-burst reset: words 1..3 still hold 0x22, 0x33, 0x44.
        @(negedge clock);
        rd = 1'b1;
        addr = 32'h204;
        burst_len = 3'd3;
        @(negedge clock);
        rd = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("mr_beat1", data_out, 32'h22);
        @(negedge clock);
        chk("mr_beat2", data_out, 32'h33);
        chk("mr_valid2", rd_valid, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mr_valid", rd_valid, 1'b0);
        chk("mr_wait", waitrequest, 1'b0);
        chk("mr_data", data_out, 32'h0);
        exp_w[0] = 32'h44;
        read_check(32'h20C, 3'd1, 1, 1'b0);

        // Collision: write wins, no read is started.
        @(negedge clock);
        rd = 1'b1;
        wr = 1'b1;
        addr = 32'h40;
        data_in = 32'h55;
        @(negedge clock);
        rd = 1'b0;
        wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("col_wait", waitrequest, 1'b0);
            chk("col_valid", rd_valid, 1'b0);
            @(negedge clock);
        end
        exp_w[0] = 32'h55;
        read_check(32'h40, 3'd0, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
